// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and transmitter state encoding
package uart_pkg;

  localparam int   DATA_BITS        = 8;
  localparam logic IDLE_LEVEL       = 1'b1;
  localparam int   DEFAULT_BAUD_DIV = 868;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered count, full and empty
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_en, pop_en;

  // Full is taken from the registered count, so a same-cycle pop never frees a slot.
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign push_en  = push && !full;
  assign pop_en   = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered 8N1 UART transmitter with FIFO status outputs
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                         XCLK,
  input  logic                         XRES,
  input  logic                         WR_VALID,
  input  logic [7:0]                   WR_DATA,
  output logic                         WR_READY,
  output logic                         TX_BUSY,
  output logic [$clog2(FIFO_DEPTH):0]  FIFO_COUNT,
  output logic                         UART_TXD
);

  localparam logic [15:0] BAUD_RELOAD = 16'(BAUD_DIV - 1);
  localparam logic [2:0]  LAST_BIT    = 3'(DATA_BITS - 1);

  tx_state_e   state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        txd_q, txd_d;
  logic        fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_head;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (XCLK),
    .rst       (XRES),
    .push      (WR_VALID),
    .push_data (WR_DATA),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .count     (FIFO_COUNT),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign WR_READY = !fifo_full;
  assign TX_BUSY  = !fifo_empty || (state_q != IDLE);
  assign UART_TXD = txd_q;

  // txd_d is the level of the state being entered, so the pin changes on the same edge.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    txd_d     = txd_q;
    fifo_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        txd_d = IDLE_LEVEL;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          baud_d   = BAUD_RELOAD;
          state_d  = START;
          txd_d    = 1'b0;
        end
      end
      START: begin
        if (baud_q == '0) begin
          baud_d    = BAUD_RELOAD;
          bit_idx_d = '0;
          state_d   = DATA;
          txd_d     = shift_q[0];
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_RELOAD;
          if (bit_idx_q == LAST_BIT) begin
            state_d = STOP;
            txd_d   = IDLE_LEVEL;
          end else begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 3'd1;
            txd_d     = shift_q[1];
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      STOP: begin
        if (baud_q == '0) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_head;
            baud_d   = BAUD_RELOAD;
            state_d  = START;
            txd_d    = 1'b0;
          end else begin
            state_d = IDLE;
            txd_d   = IDLE_LEVEL;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = IDLE_LEVEL;
      end
    endcase
  end

  always_ff @(posedge XCLK) begin
    if (XRES) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      shift_q   <= '0;
      bit_idx_q <= '0;
      txd_q     <= IDLE_LEVEL;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      txd_q     <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed and random stimulus against a frame-level line model
module tb_uart_tx_fifo;

  localparam int BD    = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * BD;

  logic       XCLK;
  logic       XRES;
  logic       WR_VALID;
  logic [7:0] WR_DATA;
  logic       WR_READY;
  logic       TX_BUSY;
  logic [2:0] FIFO_COUNT;
  logic       UART_TXD;

  uart_tx_fifo #(
    .BAUD_DIV   (BD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .XCLK       (XCLK),
    .XRES       (XRES),
    .WR_VALID   (WR_VALID),
    .WR_DATA    (WR_DATA),
    .WR_READY   (WR_READY),
    .TX_BUSY    (TX_BUSY),
    .FIFO_COUNT (FIFO_COUNT),
    .UART_TXD   (UART_TXD)
  );

  initial XCLK = 1'b0;
  always #5 XCLK = ~XCLK;

  int passes = 0;
  int total  = 0;

  // Model: a byte queue, the edge at which the line is free for the next frame,
  // and the byte/start edge of the frame currently on the wire.
  logic [7:0] mq[$];
  int         edge_n   = 0;
  int         next_pop = 0;
  bit         active   = 0;
  int         f_start  = 0;
  logic [7:0] f_byte   = 8'h00;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, edge_n, obs, exp);
  endtask

  function automatic int exp_txd();
    int k;
    if (!active) return 1;
    k = edge_n - f_start;
    if (k >= FRAME) return 1;
    k = k / BD;
    if (k == 0) return 0;
    if (k == 9) return 1;
    return int'(f_byte[k-1]);
  endfunction

  task automatic cyc(input logic v, input logic [7:0] d, input logic r);
    bit pop_now, acc;
    WR_VALID = v;
    WR_DATA  = d;
    XRES     = r;
    @(posedge XCLK);
    edge_n++;
    if (r) begin
      mq.delete();
      active   = 0;
      next_pop = 0;
    end else begin
      pop_now = (mq.size() > 0) && (edge_n >= next_pop);
      acc     = v && (mq.size() != DEPTH);
      if (pop_now) begin
        f_byte   = mq.pop_front();
        f_start  = edge_n;
        active   = 1;
        next_pop = edge_n + FRAME;
      end
      if (acc) mq.push_back(d);
    end
    #1;
    chk("uart_txd",   int'(UART_TXD),   exp_txd());
    chk("fifo_count", int'(FIFO_COUNT), mq.size());
    chk("wr_ready",   int'(WR_READY),   int'(mq.size() != DEPTH));
    chk("tx_busy",    int'(TX_BUSY),    int'((mq.size() > 0) || (active && edge_n < next_pop)));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    XRES = 1'b1;
    WR_VALID = 1'b0;
    WR_DATA = 8'h00;
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b1, 8'hEE, 1'b1);

    // single frame
    cyc(1'b1, 8'h55, 1'b0);
    idle(FRAME + 5);

    // two back-to-back frames
    cyc(1'b1, 8'h41, 1'b0);
    cyc(1'b1, 8'h0A, 1'b0);
    idle(2 * FRAME + 5);

    // overfill: sixth write dropped
    for (int i = 1; i <= 6; i++) cyc(1'b1, 8'(i), 1'b0);
    idle(5 * FRAME + 5);

    // write held against a full FIFO across the pop edge, then retried
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h60 + 8'(i), 1'b0);
    for (int i = 0; i < FRAME; i++) cyc(1'b1, 8'h7E, 1'b0);
    idle(6 * FRAME + 5);

    // reset mid-data with bytes queued, write on the reset edge ignored
    cyc(1'b1, 8'hA5, 1'b0);
    cyc(1'b1, 8'h11, 1'b0);
    cyc(1'b1, 8'h22, 1'b0);
    idle(12);
    cyc(1'b1, 8'h33, 1'b1);
    idle(FRAME + 10);

    // pointer wrap: three bursts of three
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 3; i++) cyc(1'b1, 8'h30 + 8'(3 * b + i), 1'b0);
      idle(3 * FRAME + 5);
    end

    // random traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 299) == 0);
    end
    idle(5 * FRAME + 5);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

- Buffered 8N1 UART transmitter that drives the SoC's `UART_TXD` pin.
- Sits downstream of the core's IO write path: decoded CPU stores to the UART data register are pushed into a small FIFO.
- Each byte is serialized at a fixed baud divisor.
- Exposes a not-full handshake and status so firmware can poll instead of stalling.

## Interface
Parameters:
- `BAUD_DIV`, 868: clock cycles per bit (100 MHz / 115200). Legal range 2..65535.
- `FIFO_DEPTH`, 16: FIFO entries. Power of two, 2..256.

Ports:
- `XCLK` in 1: system clock, single clock domain.
- `XRES` in 1: reset, synchronous, active-high.
- `WR_VALID` in 1: write request from IO decode.
- `WR_DATA` in 8: byte to transmit.
- `WR_READY` out 1: FIFO can accept a byte this cycle.
- `TX_BUSY` out 1: FIFO non-empty or a frame is in progress.
- `FIFO_COUNT` out $clog2(FIFO_DEPTH)+1: entries currently buffered.
- `UART_TXD` out 1: serial output, idle high.

## Operation
- **Push:** a write is accepted on any rising edge where `WR_VALID && WR_READY`.
  - `WR_READY = (FIFO_COUNT != FIFO_DEPTH)`, registered-count based.
  - A pop in the same cycle does not make a full FIFO ready.
  - A write while not ready is dropped silently; nothing else changes.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: `UART_TXD`=1. If the FIFO is non-empty, pop the head into the shift register, load the baud counter with BAUD_DIV-1 and go to START.
  - START: `UART_TXD`=0 for BAUD_DIV cycles, then go to DATA with bit index 0.
  - DATA: `UART_TXD`=shift[0], LSB first. Each bit lasts BAUD_DIV cycles, then shift right. After bit 7, go to STOP.
  - STOP: `UART_TXD`=1 for BAUD_DIV cycles.
    - At expiry, if the FIFO is non-empty, pop and go directly to START, with no idle gap between frames.
    - Otherwise go to IDLE.
- **Baud counter:** 16-bit down-counter, reloaded with BAUD_DIV-1 at each bit boundary. A bit ends when the counter reaches 0.
- **Pointers and count:**
  - Read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally.
  - The count is one bit wider.
  - Push and pop in the same cycle leave the count unchanged.
  - Pop of an empty FIFO never occurs, because the FSM checks the count.
- `TX_BUSY = (FIFO_COUNT != 0) || (state != IDLE)`.
- **Reset, including mid-frame:** on the next edge with `XRES`=1:
  - state=IDLE, pointers=0, count=0;
  - `UART_TXD`=1, `WR_READY`=1, `TX_BUSY`=0;
  - any partially sent frame is abandoned, and writes in that cycle are ignored.

## Timing
- Reset values: `UART_TXD`=1, `WR_READY`=1, `TX_BUSY`=0, `FIFO_COUNT`=0.
- `UART_TXD` is driven from a flop; no combinational path from inputs.
- Write into an empty FIFO while IDLE, accepted at edge N:
  - `FIFO_COUNT`=1 and `TX_BUSY`=1 after N;
  - pop at edge N+1;
  - `UART_TXD` falls after edge N+1.
- Frame length is exactly 10*BAUD_DIV cycles, from start-bit falling edge to the end of the stop bit.
- Back-to-back frames: the next start bit begins on the edge that ends the previous stop bit.
- `WR_READY` rises the cycle after a pop from a full FIFO.

## Structure
- **Shared package `uart_pkg`:**
  - FSM state enum (IDLE/START/DATA/STOP);
  - constants DATA_BITS=8 and IDLE_LEVEL=1'b1;
  - default baud divisor for 100 MHz/115200.
- **Sub-module `sync_fifo`:** parameterized width and depth, with push/pop/count/full/empty. It is reusable for the future UART RX path.
- The top level holds the FSM, baud counter, shift register and output flop.

## Test plan
All scenarios use BAUD_DIV=4, FIFO_DEPTH=4.
1. Reset, then write 0x55 once.
   - `UART_TXD` is low 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), then high 4 cycles.
   - Total 40 cycles; `TX_BUSY` falls after the stop bit.
2. Write 0x41, 0x0A on consecutive cycles.
   - Two contiguous 40-cycle frames, with no idle cycle between stop and start.
   - `FIFO_COUNT` sequence 1, 1, 0 at the pop points.
3. Hold `WR_VALID` for 6 cycles with data 0x01..0x06.
   - `WR_READY` drops at count 4.
   - Bytes 0x01..0x05 are transmitted (one popped early frees a slot); the byte written when not ready is dropped.
   - Check the serial stream contents.
4. Fill the FIFO and present a write on the same edge as a pop.
   - The write is rejected and the count goes 4→3.
   - `WR_READY`=1 the next cycle; a retry is accepted.
5. Assert `XRES` for 1 cycle mid-DATA of 0xA5 with 2 bytes queued.
   - `UART_TXD`=1 and `FIFO_COUNT`=0 the next cycle.
   - No further frames follow.
6. Wrap-around: send 9 bytes 0x30..0x38 in bursts of 3.
   - All 9 bytes are received in order, and the pointers wrap twice.
